// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: a Moore FSM that sequences fetch, decode,
// execute, memory and write-back, and drives the datapath strobes and selects.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   opcode, funct        - IR[31:26], IR[5:0]; sampled only in DECODE/MEMADR/IMMEX
//   zero                 - ALU zero flag (branch decision)
//   mem_ready            - memory completes the access this cycle
//   pc_we .. illegal     - 1-bit datapath strobes/selects, instr_done, illegal
//   alu_src_b, alu_op, pc_src - 2-bit selects
//   state                - current state code
// Configuration: define MC_JR_EN to add the jr (opcode 0, funct 8) state.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_we,
  output logic       alu_src_a,
  output logic       instr_done,
  output logic       illegal,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] FN_JR    = 6'd8;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_JR     = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) cur_state <= S_FETCH;
    else        cur_state <= nxt_state;
  end

  // Next-state logic
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_FETCH:  if (mem_ready) nxt_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
`ifdef MC_JR_EN
            nxt_state = (funct == FN_JR) ? S_JR : S_EXEC;
`else
            nxt_state = (funct == FN_JR) ? S_TRAP : S_EXEC;
`endif
          end
          OP_LW, OP_SW:     nxt_state = S_MEMADR;
          OP_BEQ:           nxt_state = S_BRANCH;
          OP_J:             nxt_state = S_JUMP;
          OP_ADDI, OP_ANDI: nxt_state = S_IMMEX;
          default:          nxt_state = S_TRAP;
        endcase
      end
      S_MEMADR: nxt_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) nxt_state = S_MEMWB;
      S_MEMWR:  if (mem_ready) nxt_state = S_FETCH;
      S_EXEC:   nxt_state = S_ALUWB;
      S_IMMEX:  nxt_state = S_IMMWB;
      default:  nxt_state = S_FETCH;
    endcase
  end

  // Output logic; everything forced low while reset is asserted
  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    pc_src     = 2'd0;
    state      = 4'd0;
    if (rst_n) begin
      state = 4'(cur_state);
      case (cur_state)
        S_FETCH: begin
          mem_rd    = 1'b1;
          alu_src_b = 2'd1;
          ir_we     = mem_ready;
          pc_we     = mem_ready;
        end
        S_DECODE: alu_src_b = 2'd3;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_MEMRD: begin
          iord   = 1'b1;
          mem_rd = 1'b1;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_we     = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          iord       = 1'b1;
          mem_wr     = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'd2;
        end
        S_ALUWB: begin
          reg_dst    = 1'b1;
          reg_we     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = 2'd1;
          pc_src     = 2'd1;
          pc_we      = zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_src     = 2'd2;
          pc_we      = 1'b1;
          instr_done = 1'b1;
        end
        S_IMMEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_op    = (opcode == OP_ANDI) ? 2'd3 : 2'd0;
        end
        S_IMMWB: begin
          reg_we     = 1'b1;
          instr_done = 1'b1;
        end
        S_JR: begin
          pc_src     = 2'd3;
          pc_we      = 1'b1;
          instr_done = 1'b1;
        end
        S_TRAP: begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: an instruction-level model
// expands each instruction into its expected per-cycle state/output sequence.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_we;
    logic       alu_src_a;
    logic       instr_done;
    logic       illegal;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } outs_t;

`ifdef MC_JR_EN
  localparam bit JR_EN = 1'b1;
`else
  localparam bit JR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_we, ir_we, iord, mem_rd, mem_wr, mem_to_reg, reg_dst, reg_we;
  logic       alu_src_a, instr_done, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  outs_t      obs;

  int errs   = 0;
  int checks = 0;
  logic [5:0] cur_op, cur_fn;
  logic       cur_zero;
  string      itag;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .iord(iord),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_we(reg_we), .alu_src_a(alu_src_a),
    .instr_done(instr_done), .illegal(illegal), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .state(state)
  );

  assign obs = '{pc_we, ir_we, iord, mem_rd, mem_wr, mem_to_reg, reg_dst,
                 reg_we, alu_src_a, instr_done, illegal, alu_src_b, alu_op, pc_src};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, compare at the falling edge, advance past the rising edge.
  // Opcode/funct are held only where the design may sample them; zero only in BRANCH.
  task automatic step(input logic [3:0] st, input outs_t e, input logic mr,
                      input logic hold, input logic use_z);
    mem_ready = mr;
    opcode    = hold  ? cur_op   : 6'($urandom);
    funct     = hold  ? cur_fn   : 6'($urandom);
    zero      = use_z ? cur_zero : 1'($urandom);
    @(negedge clk);
    check($sformatf("%s st%0d state", itag, st), 32'(state), 32'(st));
    check($sformatf("%s st%0d outs", itag, st), 32'(obs), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int fw);
    outs_t e;
    e = '0; e.mem_rd = 1'b1; e.alu_src_b = 2'd1;
    for (int i = 0; i < fw; i++) step(4'd0, e, 1'b0, 1'b0, 1'b0);
    e.ir_we = 1'b1; e.pc_we = 1'b1;
    step(4'd0, e, 1'b1, 1'b0, 1'b0);
    e = '0; e.alu_src_b = 2'd3;
    step(4'd1, e, 1'($urandom), 1'b1, 1'b0);
  endtask

  // Expected sequence for one instruction after decode, including memory waits.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    outs_t e;
    cur_op = op; cur_fn = fn; cur_zero = z;
    itag = $sformatf("op%0d/fn%0d", op, fn);
    fetch(fw);
    if (op == 6'd35 || op == 6'd43) begin
      e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
      step(4'd2, e, 1'($urandom), 1'b1, 1'b0);
      e = '0; e.iord = 1'b1;
      if (op == 6'd35) e.mem_rd = 1'b1; else e.mem_wr = 1'b1;
      for (int i = 0; i < mw; i++) step((op == 6'd35) ? 4'd3 : 4'd5, e, 1'b0, 1'b0, 1'b0);
      if (op == 6'd35) begin
        step(4'd3, e, 1'b1, 1'b0, 1'b0);
        e = '0; e.mem_to_reg = 1'b1; e.reg_we = 1'b1; e.instr_done = 1'b1;
        step(4'd4, e, 1'($urandom), 1'b0, 1'b0);
      end else begin
        e.instr_done = 1'b1;
        step(4'd5, e, 1'b1, 1'b0, 1'b0);
      end
    end else if (op == 6'd0 && fn == 6'd8 && JR_EN) begin
      e = '0; e.pc_src = 2'd3; e.pc_we = 1'b1; e.instr_done = 1'b1;
      step(4'd12, e, 1'($urandom), 1'b0, 1'b0);
    end else if (op == 6'd0 && fn != 6'd8) begin
      e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'd2;
      step(4'd6, e, 1'($urandom), 1'b0, 1'b0);
      e = '0; e.reg_dst = 1'b1; e.reg_we = 1'b1; e.instr_done = 1'b1;
      step(4'd7, e, 1'($urandom), 1'b0, 1'b0);
    end else if (op == 6'd4) begin
      e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'd1; e.pc_src = 2'd1;
      e.pc_we = z; e.instr_done = 1'b1;
      step(4'd8, e, 1'($urandom), 1'b0, 1'b1);
    end else if (op == 6'd2) begin
      e = '0; e.pc_src = 2'd2; e.pc_we = 1'b1; e.instr_done = 1'b1;
      step(4'd9, e, 1'($urandom), 1'b0, 1'b0);
    end else if (op == 6'd8 || op == 6'd12) begin
      e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
      e.alu_op = (op == 6'd12) ? 2'd3 : 2'd0;
      step(4'd10, e, 1'($urandom), 1'b1, 1'b0);
      e = '0; e.reg_we = 1'b1; e.instr_done = 1'b1;
      step(4'd11, e, 1'($urandom), 1'b0, 1'b0);
    end else begin
      e = '0; e.illegal = 1'b1; e.instr_done = 1'b1;
      step(4'd13, e, 1'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic reset_cycles(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom); opcode = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom);
      @(negedge clk);
      check("reset state", 32'(state), 32'd0);
      check("reset outs", 32'(obs), 32'd0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  logic [5:0] op_tab [9];
  logic [5:0] rop, rfn;
  outs_t      ef;

  initial begin
    op_tab = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd12, 6'd0, 6'd63};
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    itag = "init";
    reset_cycles(3);

    // Directed cases
    run_instr(6'd35, 6'd0, 1'b0, 0, 0);   // lw, mem_ready held high
    run_instr(6'd4,  6'd0, 1'b1, 0, 0);   // beq taken
    run_instr(6'd4,  6'd0, 1'b0, 0, 0);   // beq not taken
    run_instr(6'd43, 6'd0, 1'b0, 0, 3);   // sw with 3 wait cycles
    run_instr(6'd12, 6'd5, 1'b0, 0, 0);   // andi
    run_instr(6'd8,  6'd5, 1'b0, 0, 0);   // addi
    run_instr(6'd63, 6'd0, 1'b0, 0, 0);   // illegal
    run_instr(6'd0,  6'd8, 1'b0, 0, 0);   // jr or trap depending on build
    run_instr(6'd0,  6'd32, 1'b0, 1, 0);  // R-type
    run_instr(6'd2,  6'd0, 1'b0, 2, 0);   // j

    // Reset in the middle of a MEMRD wait
    cur_op = 6'd35; cur_fn = 6'd0; itag = "lw-rst";
    fetch(0);
    ef = '0; ef.alu_src_a = 1'b1; ef.alu_src_b = 2'd2;
    step(4'd2, ef, 1'b0, 1'b1, 1'b0);
    ef = '0; ef.iord = 1'b1; ef.mem_rd = 1'b1;
    step(4'd3, ef, 1'b0, 1'b0, 1'b0);
    reset_cycles(2);
    itag = "post-rst";
    ef = '0; ef.mem_rd = 1'b1; ef.alu_src_b = 2'd1;
    step(4'd0, ef, 1'b0, 1'b0, 1'b0);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      rop = op_tab[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) rop = 6'($urandom);
      rfn = ($urandom_range(0, 3) == 0) ? 6'd8 : 6'($urandom);
      run_instr(rop, rfn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-002 SHALL have inputs: opcode  in  6  IR[31:26]; funct  in  6  IR[5:0]; zero  in  1  ALU zero flag; mem_ready  in  1  memory completes access this cycle.
REQ-003 SHALL have 1-bit outputs: pc_we, ir_we, iord, mem_rd, mem_wr, mem_to_reg, reg_dst, reg_we, alu_src_a, instr_done, illegal. Each is a datapath strobe or select; instr_done is a one-cycle pulse on an instruction's final cycle; illegal flags an unsupported opcode.
REQ-004 SHALL have 2-bit outputs: alu_src_b (0 reg B, 1 const 4, 2 sign-ext imm, 3 imm<<2), alu_op (0 add, 1 sub, 2 use funct, 3 and), pc_src (0 ALU result, 1 ALUOut, 2 jump target, 3 reg A). SHALL have 4-bit output state, the current state code.

Function
REQ-005 SHALL be a Moore FSM with state codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, IMMEX 10, IMMWB 11, JR 12, TRAP 13. Every output not listed for a state SHALL be 0.
REQ-006 FETCH outputs: mem_rd=1, alu_src_b=1, alu_op=0, pc_src=0. ir_we=pc_we=mem_ready. If mem_ready=1 go to DECODE, else stay in FETCH.
REQ-007 DECODE outputs: alu_src_b=3, alu_op=0.
REQ-008 DECODE next state, by opcode: 0 -> EXEC, or JR if funct=8 (see REQ-017); 35, 43 -> MEMADR; 4 -> BRANCH; 2 -> JUMP; 8, 12 -> IMMEX; any other opcode -> TRAP.
REQ-009 MEMADR outputs: alu_src_a=1, alu_src_b=2, alu_op=0. Next state is MEMRD if opcode=35, else MEMWR.
REQ-010 MEMRD outputs: iord=1, mem_rd=1. Stay until mem_ready=1, then go to MEMWB.
REQ-011 MEMWB outputs: mem_to_reg=1, reg_we=1, reg_dst=0.
REQ-012 MEMWR outputs: iord=1, mem_wr=1, instr_done=mem_ready. Stay until mem_ready=1, then go to FETCH.
REQ-013 EXEC outputs: alu_src_a=1, alu_src_b=0, alu_op=2. ALUWB outputs: reg_dst=1, reg_we=1.
REQ-014 BRANCH outputs: alu_src_a=1, alu_op=1, pc_src=1, pc_we=zero. JUMP outputs: pc_src=2, pc_we=1.
REQ-015 IMMEX outputs: alu_src_a=1, alu_src_b=2; alu_op=3 if opcode=12, else 0. IMMWB outputs: reg_we=1, reg_dst=0, mem_to_reg=0.
REQ-016 TRAP outputs: illegal=1. No PC, register or memory write.
REQ-017 instr_done=1 in MEMWB, ALUWB, BRANCH, JUMP, IMMWB, JR and TRAP. These states and a completing MEMWR SHALL return to FETCH on the next clock.
REQ-018 Fixed transitions: EXEC -> ALUWB; IMMEX -> IMMWB; MEMWB, ALUWB, BRANCH, JUMP, IMMWB, JR, TRAP -> FETCH.
REQ-019 Latency with mem_ready held at 1: R-type 4 cycles, lw 5, sw 4, addi/andi 4, beq 3, j 3, jr 3, illegal 3.
REQ-020 While a memory state waits, all outputs SHALL hold stable. mem_ready SHALL be ignored in every state that is not a memory state.
REQ-021 opcode and funct SHALL be sampled only in DECODE, MEMADR and IMMEX. Changes to them in other states SHALL have no effect.

Reset
REQ-022 A clock edge with rst_n=0 SHALL force state to FETCH. This applies in any state, including a pending memory wait.
REQ-023 While rst_n=0, all outputs SHALL be driven 0 (state=0, no strobes). FETCH outputs SHALL begin in the first cycle after rst_n returns to 1.

Configuration
REQ-024 With macro MC_JR_EN defined: opcode 0 with funct 8 in DECODE SHALL go to JR, which drives pc_src=3, pc_we=1, instr_done=1.
REQ-025 Without MC_JR_EN: opcode 0 with funct 8 SHALL go to TRAP. State code 12 SHALL be unreachable.

Verification
REQ-026 Reset: rst_n=0 for 2 cycles mid-MEMRD, then release -> all outputs 0 during reset; state=0 with mem_rd=1 in the first cycle after release.
REQ-027 lw (opcode 35), mem_ready=1 -> state sequence 0,1,2,3,4; reg_we=1 and mem_to_reg=1 in cycle 5; instr_done pulses once.
REQ-028 beq (opcode 4) run twice, zero=1 then zero=0 -> state 8 reached both times; pc_we=1 with pc_src=1 when zero=1; pc_we=0 when zero=0.
REQ-029 sw with mem_ready=0 for 3 cycles in MEMWR -> state 5 held 4 cycles; mem_wr=1 throughout; instr_done=1 only in the cycle mem_ready=1.
REQ-030 andi (opcode 12) -> alu_op=3 in IMMEX; addi (opcode 8) -> alu_op=0 in IMMEX; opcode 63 -> TRAP with illegal=1, then FETCH.
REQ-031 opcode 0 with funct 8 -> JR with pc_src=3 when MC_JR_EN is defined; TRAP when it is not.
